// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB master and its tick generator.
package sccb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_ACK,
    ST_STOP,
    ST_RESTART_GAP
  } state_e;

  // Which part of the transaction the current byte belongs to.
  typedef enum logic [2:0] {
    SEG_ID_WR,
    SEG_SUBADDR,
    SEG_WDATA,
    SEG_ID_RD,
    SEG_RDATA
  } seg_e;

  localparam logic [1:0] PH_0 = 2'd0;
  localparam logic [1:0] PH_1 = 2'd1;
  localparam logic [1:0] PH_2 = 2'd2;
  localparam logic [1:0] PH_3 = 2'd3;

  localparam int         BYTE_BITS  = 8;
  localparam int         TICK_CNT_W = 12;
  localparam int         BYTE_CNT_W = 2;
  localparam logic [2:0] LAST_BIT   = 3'd7;

  // Index of the last byte in a group of n bytes.
  function automatic logic [BYTE_CNT_W-1:0] last_byte_idx(input int n);
    return BYTE_CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/sccb_master_if.sv
// Host-side handshake plus SCCB pin signals of the SCCB master.
interface sccb_master_if
  import sccb_pkg::*;
#(
  parameter int SUBADDR_BYTES = 1,
  parameter int DATA_BYTES    = 1
);

  logic                              start_i;
  logic                              rw_i;
  logic [6:0]                        id_i;
  logic [BYTE_BITS*SUBADDR_BYTES-1:0] subaddr_i;
  logic [BYTE_BITS*DATA_BYTES-1:0]    wdata_i;
  logic [BYTE_BITS*DATA_BYTES-1:0]    rdata_o;
  logic                              busy_o;
  logic                              done_o;
  logic                              ack_error_o;
  logic                              sioc_o;
  logic                              siod_oe_o;
  logic                              siod_i;

  modport master (
    input  start_i, rw_i, id_i, subaddr_i, wdata_i, siod_i,
    output rdata_o, busy_o, done_o, ack_error_o, sioc_o, siod_oe_o
  );

  modport slave (
    output start_i, rw_i, id_i, subaddr_i, wdata_i, siod_i,
    input  rdata_o, busy_o, done_o, ack_error_o, sioc_o, siod_oe_o
  );

endinterface

// File: rtl/sccb_tick_gen.sv
// Quarter-bit strobe generator; clear restarts the count so the first
// strobe after a clear lands exactly CLK_DIV cycles later.
module sccb_tick_gen
  import sccb_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam logic [TICK_CNT_W-1:0] CNT_MAX = TICK_CNT_W'(CLK_DIV - 1);

  logic [TICK_CNT_W-1:0] cnt_q, cnt_d;

  // Next count: wrap at the top, restart on clear.
  always_comb begin
    cnt_d = cnt_q + TICK_CNT_W'(1);
    if (clear_i || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/sccb_master.sv
// SCCB (I2C-like) master: write and split read (STOP + gap + START)
// transactions with 4-tick bit slots and slave NACK abort.
module sccb_master
  import sccb_pkg::*;
#(
  parameter int CLK_DIV       = 250,
  parameter int SUBADDR_BYTES = 1,
  parameter int DATA_BYTES    = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  sccb_master_if.master bus
);

  localparam int SUB_W = BYTE_BITS * SUBADDR_BYTES;
  localparam int DAT_W = BYTE_BITS * DATA_BYTES;
  localparam logic [BYTE_CNT_W-1:0] LAST_SUB  = last_byte_idx(SUBADDR_BYTES);
  localparam logic [BYTE_CNT_W-1:0] LAST_DATA = last_byte_idx(DATA_BYTES);

  state_e                state_q, state_d;
  seg_e                  seg_q, seg_d;
  logic [1:0]            phase_q, phase_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]            shreg_q, shreg_d;
  logic [6:0]            id_q, id_d;
  logic [SUB_W-1:0]      sub_q, sub_d;
  logic [DAT_W-1:0]      wdata_q, wdata_d;
  logic [DAT_W-1:0]      rx_q, rx_d;
  logic [DAT_W-1:0]      rdata_q, rdata_d;
  logic                  rw_q, rw_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ack_err_q, ack_err_d;
  logic                  restart_q, restart_d;
  logic                  accept;
  logic                  tick;
  logic                  sioc;
  logic                  siod_oe;

  sccb_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (accept),
    .tick_o  (tick)
  );

  // State register: every flop of the master, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      seg_q      <= SEG_ID_WR;
      phase_q    <= PH_0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
      id_q       <= '0;
      sub_q      <= '0;
      wdata_q    <= '0;
      rx_q       <= '0;
      rdata_q    <= '0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      restart_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
      id_q       <= id_d;
      sub_q      <= sub_d;
      wdata_q    <= wdata_d;
      rx_q       <= rx_d;
      rdata_q    <= rdata_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      restart_q  <= restart_d;
    end
  end

  // Next state: accept in IDLE, otherwise advance one phase per tick and
  // move between states at the end of phase 3.
  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
    id_d       = id_q;
    sub_d      = sub_q;
    wdata_d    = wdata_q;
    rx_d       = rx_q;
    rdata_d    = rdata_q;
    rw_d       = rw_q;
    ack_err_d  = ack_err_q;
    restart_d  = restart_q;
    busy_d     = busy_q & ~done_q;
    done_d     = 1'b0;
    accept     = 1'b0;

    if (state_q == ST_IDLE) begin
      if (bus.start_i && !busy_q) begin
        accept     = 1'b1;
        state_d    = ST_START;
        seg_d      = SEG_ID_WR;
        phase_d    = PH_0;
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
        rw_d       = bus.rw_i;
        id_d       = bus.id_i;
        sub_d      = bus.subaddr_i;
        wdata_d    = bus.wdata_i;
        shreg_d    = {bus.id_i, 1'b0};
        ack_err_d  = 1'b0;
        restart_d  = 1'b0;
        busy_d     = 1'b1;
      end
    end else if (tick) begin
      phase_d = phase_q + 2'd1;
      case (state_q)
        ST_START: begin
          if (phase_q == PH_3) begin
            state_d   = ST_BIT;
            bit_cnt_d = '0;
          end
        end
        ST_BIT: begin
          if ((phase_q == PH_2) && (seg_q == SEG_RDATA)) begin
            rx_d = {rx_q[DAT_W-2:0], bus.siod_i};
          end
          if (phase_q == PH_3) begin
            if (bit_cnt_q == LAST_BIT) begin
              state_d = ST_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              shreg_d   = {shreg_q[6:0], 1'b0};
            end
          end
        end
        ST_ACK: begin
          if ((phase_q == PH_2) && (seg_q != SEG_RDATA) && bus.siod_i) begin
            ack_err_d = 1'b1;
          end
          if (phase_q == PH_3) begin
            bit_cnt_d = '0;
            state_d   = ST_BIT;
            if (ack_err_q) begin
              state_d = ST_STOP;
            end else begin
              case (seg_q)
                SEG_ID_WR: begin
                  seg_d      = SEG_SUBADDR;
                  byte_cnt_d = '0;
                  shreg_d    = sub_q[SUB_W-1 -: BYTE_BITS];
                  sub_d      = sub_q << BYTE_BITS;
                end
                SEG_SUBADDR: begin
                  if (byte_cnt_q != LAST_SUB) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    shreg_d    = sub_q[SUB_W-1 -: BYTE_BITS];
                    sub_d      = sub_q << BYTE_BITS;
                  end else if (rw_q) begin
                    seg_d      = SEG_WDATA;
                    byte_cnt_d = '0;
                    shreg_d    = wdata_q[DAT_W-1 -: BYTE_BITS];
                    wdata_d    = wdata_q << BYTE_BITS;
                  end else begin
                    state_d   = ST_STOP;
                    restart_d = 1'b1;
                  end
                end
                SEG_WDATA: begin
                  if (byte_cnt_q == LAST_DATA) begin
                    state_d = ST_STOP;
                  end else begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    shreg_d    = wdata_q[DAT_W-1 -: BYTE_BITS];
                    wdata_d    = wdata_q << BYTE_BITS;
                  end
                end
                SEG_ID_RD: begin
                  seg_d      = SEG_RDATA;
                  byte_cnt_d = '0;
                end
                default: begin
                  if (byte_cnt_q == LAST_DATA) begin
                    state_d = ST_STOP;
                  end else begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                  end
                end
              endcase
            end
          end
        end
        ST_STOP: begin
          if (phase_q == PH_3) begin
            if (restart_q) begin
              state_d   = ST_RESTART_GAP;
              restart_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              if (!rw_q && !ack_err_q) begin
                rdata_d = rx_q;
              end
            end
          end
        end
        ST_RESTART_GAP: begin
          if (phase_q == PH_3) begin
            state_d = ST_START;
            seg_d   = SEG_ID_RD;
            shreg_d = {id_q, 1'b1};
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Pin levels from state and phase: SCL low in phases 0-1 of bit slots,
  // SDA pulled low for 0 bits, START/STOP edges and master ACKs.
  always_comb begin
    sioc    = 1'b1;
    siod_oe = 1'b0;
    case (state_q)
      ST_START: begin
        siod_oe = phase_q[1];
      end
      ST_BIT: begin
        sioc    = phase_q[1];
        siod_oe = (seg_q != SEG_RDATA) && !shreg_q[7];
      end
      ST_ACK: begin
        sioc    = phase_q[1];
        siod_oe = (seg_q == SEG_RDATA) && (byte_cnt_q != LAST_DATA);
      end
      ST_STOP: begin
        sioc    = (phase_q != PH_0);
        siod_oe = !phase_q[1];
      end
      default: begin
        sioc    = 1'b1;
        siod_oe = 1'b0;
      end
    endcase
  end

  assign bus.sioc_o      = sioc;
  assign bus.siod_oe_o   = siod_oe;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.ack_error_o = ack_err_q;
  assign bus.rdata_o     = rdata_q;

endmodule
